// File: rtl/mini68k_sequencer.sv
// mini68k_sequencer: main fetch/decode/execute control FSM of the Mini68k core
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   mem_req_o, mem_ack_i            instruction-stream read handshake (address is PC)
//   ir_load_o, ext_load_o, ext_idx_o   latch read data into IR / extension word ext_idx_o
//   pc_inc_o, pc_load_o             PC += 2 / PC <= branch or jump target
//   is_*_i, op_size_i, cond_true_i  decoder classification and Bcc condition
//   alu_start_o, alu_done_i         ALU/move handshake
//   reg_we_o                        register-file write strobe
//   illegal_o, bus_err_o, halted_o  sticky fault flags and halt indicator
//   state_o, retired_o              debug state and retired-instruction count
module mini68k_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req_o,
    input  logic             mem_ack_i,
    output logic             ir_load_o,
    output logic             ext_load_o,
    output logic             ext_idx_o,
    output logic             pc_inc_o,
    output logic             pc_load_o,
    input  logic             is_move_i,
    input  logic             is_alu_i,
    input  logic             is_branch_i,
    input  logic             is_jump_i,
    input  logic             is_immediate_i,
    input  logic [1:0]       op_size_i,
    input  logic             cond_true_i,
    output logic             alu_start_o,
    input  logic             alu_done_i,
    output logic             reg_we_o,
    output logic             illegal_o,
    output logic             bus_err_o,
    output logic             halted_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired_o
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IFETCH   = 3'd0,
        DECODE   = 3'd1,
        EXTFETCH = 3'd2,
        EXEC     = 3'd3,
        WB       = 3'd4,
        BRANCH   = 3'd5,
        JUMP     = 3'd6,
        HALT     = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       words_q, words_d;
    logic             ext_idx_q, ext_idx_d;
    logic             first_q;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             illegal_q, bus_err_q, set_ill, set_be;
    logic [CNT_W-1:0] retired_q;
    logic             fetch, tmo_hit, retire, run;

    assign fetch   = (state_q == IFETCH) || (state_q == EXTFETCH);
    // an ack in the last allowed cycle takes precedence over the timeout
    assign tmo_hit = fetch && !mem_ack_i && (tmo_q == TW'(TIMEOUT - 1));
    assign retire  = (state_q == WB) || (state_q == BRANCH) || (state_q == JUMP);
    // counter is zero on entry to a fetch state and restarts after every ack
    assign tmo_d   = (fetch && !mem_ack_i) ? tmo_q + 1'b1 : '0;
    // strobes are suppressed while reset is asserted so an abort emits nothing
    assign run     = !rst;

    always_comb begin
        state_d   = state_q;
        words_d   = words_q;
        ext_idx_d = ext_idx_q;
        set_ill   = 1'b0;
        set_be    = 1'b0;
        case (state_q)
            IFETCH: begin
                state_d = mem_ack_i ? DECODE : tmo_hit ? HALT : IFETCH;
                set_be  = tmo_hit;
            end
            DECODE: begin
                state_d   = is_immediate_i ? EXTFETCH :
                            (is_move_i || is_alu_i) ? EXEC :
                            is_branch_i ? BRANCH :
                            is_jump_i ? JUMP : HALT;
                words_d   = (op_size_i == 2'b10) ? 2'd2 : 2'd1;
                ext_idx_d = is_immediate_i ? 1'b0 : ext_idx_q;
                set_ill   = !(is_immediate_i || is_move_i || is_alu_i || is_branch_i || is_jump_i);
            end
            EXTFETCH: begin
                words_d   = mem_ack_i ? words_q - 2'd1 : words_q;
                ext_idx_d = (mem_ack_i && words_q == 2'd2) ? 1'b1 : ext_idx_q;
                state_d   = mem_ack_i ? ((words_q == 2'd1) ? EXEC : EXTFETCH) :
                            tmo_hit ? HALT : EXTFETCH;
                set_be    = tmo_hit;
            end
            EXEC:             state_d = alu_done_i ? WB : EXEC;
            WB, BRANCH, JUMP: state_d = IFETCH;
            default:          state_d = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IFETCH;
            words_q   <= '0;
            ext_idx_q <= 1'b0;
            first_q   <= 1'b0;
            tmo_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            words_q   <= words_d;
            ext_idx_q <= ext_idx_d;
            first_q   <= (state_d == EXEC) && (state_q != EXEC);
            tmo_q     <= tmo_d;
            illegal_q <= illegal_q | set_ill;
            bus_err_q <= bus_err_q | set_be;
            retired_q <= retire ? retired_q + 1'b1 : retired_q;
        end
    end

    assign mem_req_o   = fetch;
    assign ir_load_o   = run && (state_q == IFETCH) && mem_ack_i;
    assign ext_load_o  = run && (state_q == EXTFETCH) && mem_ack_i;
    assign pc_inc_o    = run && fetch && mem_ack_i;
    assign pc_load_o   = run && ((state_q == JUMP) || ((state_q == BRANCH) && cond_true_i));
    assign alu_start_o = run && (state_q == EXEC) && first_q;
    assign reg_we_o    = run && (state_q == WB);
    assign ext_idx_o   = ext_idx_q;
    assign illegal_o   = illegal_q;
    assign bus_err_o   = bus_err_q;
    assign halted_o    = (state_q == HALT);
    assign state_o     = state_q;
    assign retired_o   = retired_q;
endmodule

// File: tb/tb_mini68k_sequencer.sv
// tb_mini68k_sequencer: scoreboard bench with randomized instruction stream and reference model
module tb_mini68k_sequencer;
    localparam int T  = 4;
    localparam int CW = 4;
    localparam int C_MOVE = 0, C_ALU = 1, C_BR = 2, C_JMP = 3, C_IMMW = 4, C_IMML = 5, C_ILL = 6;
    // strobe record: {ir_load, ext_load, ext_idx (when ext_load), pc_inc, pc_load, alu_start, reg_we}
    localparam logic [6:0] E_IR   = 7'b1001000;
    localparam logic [6:0] E_EXT0 = 7'b0101000;
    localparam logic [6:0] E_EXT1 = 7'b0111000;
    localparam logic [6:0] E_PCL  = 7'b0000100;
    localparam logic [6:0] E_ALU  = 7'b0000010;
    localparam logic [6:0] E_WB   = 7'b0000001;

    logic clk = 1'b0, rst = 1'b1;
    logic mem_req_o, mem_ack_i = 1'b0, ir_load_o, ext_load_o, ext_idx_o, pc_inc_o, pc_load_o;
    logic is_move_i = 1'b0, is_alu_i = 1'b0, is_branch_i = 1'b0, is_jump_i = 1'b0, is_immediate_i = 1'b0;
    logic [1:0] op_size_i = 2'b00;
    logic cond_true_i = 1'b0, alu_start_o, alu_done_i = 1'b0, reg_we_o;
    logic illegal_o, bus_err_o, halted_o;
    logic [2:0] state_o;
    logic [CW-1:0] retired_o;

    int checks = 0, errors = 0;
    logic [6:0] exp_q[$];
    logic [6:0] obs, e;
    int exp_ret = 0;
    bit tr_en = 1'b0;
    int tr_code = 1;

    always #5 clk = ~clk;

    mini68k_sequencer #(.TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i),
        .ir_load_o(ir_load_o), .ext_load_o(ext_load_o), .ext_idx_o(ext_idx_o),
        .pc_inc_o(pc_inc_o), .pc_load_o(pc_load_o), .is_move_i(is_move_i),
        .is_alu_i(is_alu_i), .is_branch_i(is_branch_i), .is_jump_i(is_jump_i),
        .is_immediate_i(is_immediate_i), .op_size_i(op_size_i), .cond_true_i(cond_true_i),
        .alu_start_o(alu_start_o), .alu_done_i(alu_done_i), .reg_we_o(reg_we_o),
        .illegal_o(illegal_o), .bus_err_o(bus_err_o), .halted_o(halted_o),
        .state_o(state_o), .retired_o(retired_o)
    );

    task automatic chk(string nm, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    // monitor: every cycle with any strobe consumes one expected record
    initial forever begin
        @(negedge clk);
        obs = {ir_load_o, ext_load_o, ext_load_o & ext_idx_o, pc_inc_o, pc_load_o, alu_start_o, reg_we_o};
        if (tr_en) tr_code = tr_code * 16 + int'(state_o);
        if (obs != 7'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe: got %b expected none", obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL strobe: got %b expected %b", obs, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic clear_inputs();
        {mem_ack_i, alu_done_i, cond_true_i, is_move_i, is_alu_i, is_branch_i, is_jump_i, is_immediate_i, op_size_i} = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {mem_ack_i, alu_done_i, cond_true_i, is_move_i, is_alu_i, is_branch_i, is_jump_i, is_immediate_i} = '1;
        @(posedge clk); #1;
        chk("rst_state", int'(state_o), 0);
        @(negedge clk);
        chk("rst_retired", int'(retired_o), 0);
        chk("rst_illegal", int'(illegal_o), 0);
        chk("rst_bus_err", int'(bus_err_o), 0);
        chk("rst_halted", int'(halted_o), 0);
        chk("rst_ext_idx", int'(ext_idx_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        chk("leftover", exp_q.size(), 0);
        exp_q.delete();
        exp_ret = 0;
    endtask

    task automatic drive_dec(int cls);
        logic [4:0] r;
        r = 5'($urandom);
        is_immediate_i = (cls == C_IMMW) || (cls == C_IMML);
        is_move_i      = (cls == C_MOVE) || (is_immediate_i && r[0]);
        is_alu_i       = (cls == C_ALU) || (((cls == C_MOVE) || is_immediate_i) && r[1]);
        is_branch_i    = (cls == C_BR) || (((cls <= C_ALU) || is_immediate_i) && r[2]);
        is_jump_i      = (cls == C_JMP) || ((cls != C_ILL) && r[3]);
        op_size_i      = (cls == C_IMML) ? 2'b10 : (cls == C_IMMW) ? {1'b0, r[4]} : 2'($urandom);
    endtask

    task automatic fetch(int d);
        int n = 0;
        while (!mem_req_o && n < 20) begin @(posedge clk); #1; n++; end
        chk("req_seen", int'(mem_req_o), 1);
        if (d >= T) begin
            repeat (T) begin alu_done_i = 1'($urandom); @(posedge clk); #1; end
            alu_done_i = 1'b0;
            chk("timeout_halt", int'(state_o), 7);
        end else begin
            repeat (d) begin alu_done_i = 1'($urandom); @(posedge clk); #1; end
            alu_done_i = 1'b0;
            mem_ack_i = 1'b1;
            @(posedge clk); #1;
            mem_ack_i = 1'b0;
        end
    endtask

    task automatic exec_alu(int ad);
        int n = 0;
        while (!alu_start_o && n < 20) begin @(posedge clk); #1; n++; end
        chk("alu_start_seen", int'(alu_start_o), 1);
        repeat (ad) begin mem_ack_i = 1'($urandom); @(posedge clk); #1; end
        mem_ack_i = 1'b0;
        alu_done_i = 1'b1;
        @(posedge clk); #1;
        alu_done_i = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (state_o != 3'd0 && state_o != 3'd7 && n < 40) begin @(posedge clk); #1; n++; end
    endtask

    task automatic run_instr(int cls, int d0, int d1, int d2, bit cond, int ad);
        int halt = 0;
        int n;
        int dw[2];
        bit imm, exe, stop;
        n = (cls == C_IMML) ? 2 : 1;
        dw[0] = d1;
        dw[1] = d2;
        imm = (cls == C_IMMW) || (cls == C_IMML);
        exe = imm || (cls == C_MOVE) || (cls == C_ALU);
        // reference model: expected strobe records and outcome of one instruction
        if (d0 >= T) halt = 2;
        else begin
            exp_q.push_back(E_IR);
            if (cls == C_ILL) halt = 1;
            if (imm)
                for (int w = 0; w < n && halt == 0; w++)
                    if (dw[w] >= T) halt = 2;
                    else exp_q.push_back(w == 0 ? E_EXT0 : E_EXT1);
            if (halt == 0) begin
                if (exe) begin exp_q.push_back(E_ALU); exp_q.push_back(E_WB); end
                else if (cls == C_JMP || (cls == C_BR && cond)) exp_q.push_back(E_PCL);
                exp_ret = (exp_ret + 1) % (1 << CW);
            end
        end
        drive_dec(cls);
        cond_true_i = cond;
        tr_code = 1;
        tr_en = 1'b1;
        fetch(d0);
        if (d0 < T) begin
            stop = 1'b0;
            if (imm)
                for (int w = 0; w < n && !stop; w++) begin
                    fetch(dw[w]);
                    stop = dw[w] >= T;
                end
            if (halt == 0 && exe) exec_alu(ad);
        end
        wait_end();
        tr_en = 1'b0;
        if (halt == 0) begin
            chk("end_state", int'(state_o), 0);
            chk("halted_low", int'(halted_o), 0);
            chk("retired", int'(retired_o), exp_ret);
            chk("pending", exp_q.size(), 0);
            exp_q.delete();
        end else begin
            chk("halt_state", int'(state_o), 7);
            chk("halted", int'(halted_o), 1);
            chk("illegal", int'(illegal_o), int'(halt == 1));
            chk("bus_err", int'(bus_err_o), int'(halt == 2));
            chk("halt_req", int'(mem_req_o), 0);
            repeat (4) begin
                {mem_ack_i, alu_done_i, cond_true_i, is_move_i, is_alu_i, is_branch_i, is_jump_i, is_immediate_i, op_size_i} = 10'($urandom);
                @(posedge clk); #1;
            end
            clear_inputs();
            chk("halt_absorb", int'(state_o), 7);
            do_reset();
        end
    endtask

    function automatic int rd();
        return ($urandom_range(0, 11) == 0) ? T : int'($urandom_range(0, T - 1));
    endfunction

    initial begin
        int n;
        do_reset();
        run_instr(C_MOVE, 0, 0, 0, 1'b0, 0);  chk("trace_move", tr_code, 'h10134);
        run_instr(C_IMMW, 0, 0, 0, 1'b0, 0);  chk("trace_oriw", tr_code, 'h101234);
        run_instr(C_IMML, 0, 0, 0, 1'b0, 0);  chk("trace_oril", tr_code, 'h1012234);
        run_instr(C_BR, 0, 0, 0, 1'b1, 0);    chk("trace_bcc_t", tr_code, 'h1015);
        run_instr(C_BR, 0, 0, 0, 1'b0, 0);    chk("trace_bcc_f", tr_code, 'h1015);
        run_instr(C_JMP, 0, 0, 0, 1'b0, 0);   chk("trace_jmp", tr_code, 'h1016);
        run_instr(C_ILL, 0, 0, 0, 1'b0, 0);   chk("trace_ill", tr_code, 'h101);
        run_instr(C_MOVE, T, 0, 0, 1'b0, 0);  chk("trace_tmo", tr_code, 'h10000);
        run_instr(C_MOVE, T - 1, 0, 0, 1'b0, 0); chk("trace_ack_last", tr_code, 'h10000134);
        run_instr(C_ALU, 0, 0, 0, 1'b0, 5);
        // reset while the ALU is stalled: no reg_we may follow
        exp_q.push_back(E_IR);
        exp_q.push_back(E_ALU);
        drive_dec(C_ALU);
        fetch(0);
        n = 0;
        while (!alu_start_o && n < 20) begin @(posedge clk); #1; n++; end
        repeat (2) begin @(posedge clk); #1; end
        chk("exec_stall", int'(state_o), 3);
        do_reset();
        chk("ret_after_abort", int'(retired_o), 0);
        repeat (17) run_instr(C_JMP, 0, 0, 0, 1'b0, 0);
        chk("retired_wrap", int'(retired_o), 1);
        repeat (80) run_instr(int'($urandom_range(0, 6)), rd(), rd(), rd(), 1'($urandom), int'($urandom_range(0, 4)));
        chk("final_pending", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
